// File: rtl/traffic_pkg.sv
// Shared definitions for the four-phase traffic-light controller and its
// lamp-side consumers: phase encodings, default timing, error bit positions.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_NS_G = 2'd0,
    PH_NS_Y = 2'd1,
    PH_EW_G = 2'd2,
    PH_EW_Y = 2'd3
  } phase_t;

  localparam int G_TICKS_DFLT = 5;
  localparam int Y_TICKS_DFLT = 2;

  localparam int ERR_W     = 5;
  localparam int ERR_LAMP  = 4;
  localparam int ERR_SEQ   = 3;
  localparam int ERR_SHORT = 2;
  localparam int ERR_LONG  = 1;
  localparam int ERR_EARLY = 0;

  // Legal successor in the fixed NS_G -> NS_Y -> EW_G -> EW_Y ring.
  function automatic phase_t next_phase(input phase_t ph);
    case (ph)
      PH_NS_G: return PH_NS_Y;
      PH_NS_Y: return PH_EW_G;
      PH_EW_G: return PH_EW_Y;
      default: return PH_NS_G;
    endcase
  endfunction

endpackage

// File: rtl/traffic_lamp_decode.sv
// Combinational decode of the six lamp lines into a phase code. Only the four
// exact one-green/one-red or one-yellow/one-red patterns are valid; anything
// else (dark, conflicting greens, extra lamps lit) reports valid = 0.
module traffic_lamp_decode
  import traffic_pkg::*;
(
  input  logic       ns_g,
  input  logic       ns_y,
  input  logic       ns_r,
  input  logic       ew_g,
  input  logic       ew_y,
  input  logic       ew_r,
  output logic       valid,
  output logic [1:0] phase
);

  logic [5:0] lamps;
  assign lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};

  // Exact-pattern match; phase defaults to NS_G when the pattern is invalid.
  always_comb begin
    valid = 1'b1;
    phase = PH_NS_G;
    case (lamps)
      6'b100_001: phase = PH_NS_G;
      6'b010_001: phase = PH_NS_Y;
      6'b001_100: phase = PH_EW_G;
      6'b001_010: phase = PH_EW_Y;
      default:    valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive watchdog on the traffic-light lamp interface. Tracks the current
// phase, counts ticks per phase and flags illegal lamps, out-of-order phases,
// short/long phases and changes not aligned to the terminal tick.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int G_TICKS = G_TICKS_DFLT,
  parameter int Y_TICKS = Y_TICKS_DFLT,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             ns_g,
  input  logic             ns_y,
  input  logic             ns_r,
  input  logic             ew_g,
  input  logic             ew_y,
  input  logic             ew_r,
  input  logic             clr_err,
  output logic [4:0]       err_flags,
  output logic             err_pulse,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DUR_MAX = (G_TICKS > Y_TICKS) ? G_TICKS : Y_TICKS;
  // One extra code above DUR_MAX holds the saturated "already overran" value.
  localparam int TW      = $clog2(DUR_MAX + 2);

  typedef enum logic {
    MODE_TRACK = 1'b0,
    MODE_SYNC  = 1'b1
  } mode_t;

  mode_t          mode_q, mode_d;
  phase_t         cur_ph_q, cur_ph_d;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic           tick_q;
  // In SYNC: the previous sample was a valid phase, so a change can be judged.
  logic           sync_seen_q, sync_seen_d;
  logic [4:0]     new_err;
  logic           cyc_inc;

  logic           obs_valid;
  logic [1:0]     obs_raw;
  phase_t         obs;

  traffic_lamp_decode u_decode (
    .ns_g  (ns_g),
    .ns_y  (ns_y),
    .ns_r  (ns_r),
    .ew_g  (ew_g),
    .ew_y  (ew_y),
    .ew_r  (ew_r),
    .valid (obs_valid),
    .phase (obs_raw)
  );

  assign obs = phase_t'(obs_raw);

  function automatic logic [TW-1:0] dur_of(input phase_t ph);
    if (ph == PH_NS_Y || ph == PH_EW_Y) return TW'(Y_TICKS);
    return TW'(G_TICKS);
  endfunction

  // Next-state and error detection for the tracking/resync FSM.
  always_comb begin
    mode_d      = mode_q;
    cur_ph_d    = cur_ph_q;
    tick_cnt_d  = tick_cnt_q;
    sync_seen_d = sync_seen_q;
    new_err     = '0;
    cyc_inc     = 1'b0;
    if (mode_q == MODE_TRACK) begin
      if (!obs_valid) begin
        new_err[ERR_LAMP] = 1'b1;
        mode_d            = MODE_SYNC;
        sync_seen_d       = 1'b0;
      end else if (obs == cur_ph_q) begin
        if (tick) begin
          if (tick_cnt_q < dur_of(cur_ph_q)) begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end else if (tick_cnt_q == dur_of(cur_ph_q)) begin
            new_err[ERR_LONG] = 1'b1;
            tick_cnt_d        = dur_of(cur_ph_q) + TW'(1);
          end
        end
      end else begin
        if (obs != next_phase(cur_ph_q)) new_err[ERR_SEQ] = 1'b1;
        else if (cur_ph_q == PH_EW_Y)    cyc_inc = 1'b1;
        if (tick_cnt_q < dur_of(cur_ph_q)) new_err[ERR_SHORT] = 1'b1;
        // The controller moves exactly one clk after its terminal tick.
        if (!tick_q) new_err[ERR_EARLY] = 1'b1;
        cur_ph_d   = obs;
        tick_cnt_d = tick ? TW'(1) : '0;
      end
    end else begin
      if (!obs_valid) begin
        sync_seen_d = 1'b0;
      end else begin
        if (sync_seen_q && obs == next_phase(cur_ph_q)) begin
          mode_d     = MODE_TRACK;
          tick_cnt_d = tick ? TW'(1) : '0;
        end
        cur_ph_d    = obs;
        sync_seen_d = 1'b1;
      end
    end
  end

  // State, sticky error and cycle-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_TRACK;
      cur_ph_q    <= PH_NS_G;
      tick_cnt_q  <= '0;
      tick_q      <= 1'b0;
      sync_seen_q <= 1'b0;
      err_flags   <= '0;
      err_pulse   <= 1'b0;
      cycle_count <= '0;
    end else begin
      mode_q      <= mode_d;
      cur_ph_q    <= cur_ph_d;
      tick_cnt_q  <= tick_cnt_d;
      tick_q      <= tick;
      sync_seen_q <= sync_seen_d;
      err_flags   <= (clr_err ? 5'b0 : err_flags) | new_err;
      err_pulse   <= |new_err;
      if (cyc_inc) cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  assign phase       = cur_ph_q;
  assign phase_valid = (mode_q == MODE_TRACK);

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus a randomized
// controller-like stimulus checked against a behavioural reference model.
module tb_traffic_light_monitor;

  localparam int G  = 5;
  localparam int Y  = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, tick, clr_err;
  logic          ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
  logic [4:0]    err_flags;
  logic          err_pulse;
  logic [1:0]    phase;
  logic          phase_valid;
  logic [CW-1:0] cycle_count;

  traffic_light_monitor #(.G_TICKS(G), .Y_TICKS(Y), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
    .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .clr_err(clr_err), .err_flags(err_flags), .err_pulse(err_pulse),
    .phase(phase), .phase_valid(phase_valid), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // One clk of stimulus: ph 0..3 = lamp phase, 4 = both greens, 5 = dark, 6 = all on.
  typedef struct {int ph; bit tk;} cyc_t;
  cyc_t plan[$];

  // Reference model state: phase, ticks seen in it (uncapped), resync status.
  bit          m_track, m_have, m_ptick, m_pulse;
  int          m_ph, m_ticks;
  logic [4:0]  m_flags;
  int unsigned m_cycles;

  function automatic int dur(input int ph);
    return (ph % 2 == 1) ? Y : G;
  endfunction

  task automatic set_lamps(input int ph);
    case (ph)
      0:       {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = 6'b100001;
      1:       {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = 6'b010001;
      2:       {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = 6'b001100;
      3:       {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = 6'b001010;
      4:       {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = 6'b100100;
      5:       {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = 6'b000000;
      default: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = 6'b111111;
    endcase
  endtask

  task automatic model_step(input int ph, input bit tk, input bit r, input bit clr);
    logic [4:0] ne;
    ne = '0;
    if (r) begin
      m_track = 1; m_have = 0; m_ptick = 0; m_pulse = 0;
      m_ph = 0; m_ticks = 0; m_flags = '0; m_cycles = 0;
    end else begin
      if (m_track) begin
        if (ph > 3) begin
          ne[4] = 1'b1; m_track = 0; m_have = 0;
        end else if (ph == m_ph) begin
          if (tk) begin
            m_ticks++;
            if (m_ticks == dur(m_ph) + 1) ne[1] = 1'b1;
          end
        end else begin
          if (ph != (m_ph + 1) % 4) ne[3] = 1'b1;
          else if (m_ph == 3) m_cycles++;
          if (m_ticks < dur(m_ph)) ne[2] = 1'b1;
          if (!m_ptick) ne[0] = 1'b1;
          m_ph = ph; m_ticks = tk;
        end
      end else if (ph <= 3) begin
        if (m_have && ph == (m_ph + 1) % 4) begin
          m_track = 1; m_ticks = tk;
        end
        m_ph = ph; m_have = 1;
      end else begin
        m_have = 0;
      end
      m_flags = (clr ? 5'b0 : m_flags) | ne;
      m_pulse = |ne;
      m_ptick = tk;
    end
  endtask

  task automatic cyc(input int ph, input bit tk, input bit r = 1'b0, input bit clr = 1'b0);
    set_lamps(ph);
    tick = tk; rst = r; clr_err = clr;
    @(posedge clk);
    model_step(ph, tk, r, clr);
    #1;
  endtask

  // Controller-style phase: n ticks, one every per clks, then post idle clks.
  task automatic plan_phase(input int ph, input int n, input int per, input int post);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < per - 1; j++) plan.push_back('{ph, 1'b0});
      plan.push_back('{ph, 1'b1});
    end
    for (int j = 0; j < post; j++) plan.push_back('{ph, 1'b0});
  endtask

  task automatic run_plan();
    cyc_t e;
    while (plan.size() > 0) begin
      e = plan.pop_front();
      cyc(e.ph, e.tk);
    end
  endtask

  task automatic do_reset();
    plan.delete();
    cyc(0, 1'b0, 1'b1);
    cyc(0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (err_flags !== 5'b0) begin n_bad++; $display("FAIL reset_flags got %b want 00000", err_flags); end
    n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse got %b want 0", err_pulse); end
    n_cmp++; if (phase !== 2'd0) begin n_bad++; $display("FAIL reset_phase got %0d want 0", phase); end
    n_cmp++; if (phase_valid !== 1'b1) begin n_bad++; $display("FAIL reset_valid got %b want 1", phase_valid); end
    n_cmp++; if (cycle_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", cycle_count); end
  endtask

  task automatic test_normal();
    cyc_t e;
    do_reset();
    for (int i = 0; i < 12; i++) plan_phase(i % 4, dur(i % 4), 4, 0);
    plan.push_back('{0, 1'b0});
    while (plan.size() > 0) begin
      e = plan.pop_front();
      cyc(e.ph, e.tk);
      n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL normal_pulse got %b want 0", err_pulse); end
      n_cmp++; if (phase !== e.ph[1:0]) begin n_bad++; $display("FAIL normal_phase got %0d want %0d", phase, e.ph); end
    end
    n_cmp++; if (err_flags !== 5'b0) begin n_bad++; $display("FAIL normal_flags got %b want 00000", err_flags); end
    n_cmp++; if (cycle_count !== 16'd3) begin n_bad++; $display("FAIL normal_count got %0d want 3", cycle_count); end
  endtask

  task automatic test_short();
    do_reset();
    plan_phase(0, 4, 4, 0);
    run_plan();
    cyc(1, 1'b0);
    n_cmp++; if (err_flags !== 5'b00100) begin n_bad++; $display("FAIL short_flags got %b want 00100", err_flags); end
    n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL short_pulse got %b want 1", err_pulse); end
    n_cmp++; if (phase !== 2'd1) begin n_bad++; $display("FAIL short_phase got %0d want 1", phase); end
    cyc(1, 1'b0);
    n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL short_pulse2 got %b want 0", err_pulse); end
  endtask

  task automatic test_long();
    cyc_t e;
    do_reset();
    plan_phase(0, 6, 4, 0);
    run_plan();
    n_cmp++; if (err_flags !== 5'b00010) begin n_bad++; $display("FAIL long_flags got %b want 00010", err_flags); end
    n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL long_pulse got %b want 1", err_pulse); end
    plan_phase(0, 1, 4, 1);
    while (plan.size() > 0) begin
      e = plan.pop_front();
      cyc(e.ph, e.tk);
      n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL long_repulse got %b want 0", err_pulse); end
    end
    n_cmp++; if (err_flags !== 5'b00010) begin n_bad++; $display("FAIL long_flags2 got %b want 00010", err_flags); end
  endtask

  task automatic test_lamp();
    cyc_t e;
    do_reset();
    plan_phase(0, G, 4, 0);
    run_plan();
    cyc(4, 1'b0);
    n_cmp++; if (err_flags !== 5'b10000) begin n_bad++; $display("FAIL lamp_flags got %b want 10000", err_flags); end
    n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL lamp_pulse got %b want 1", err_pulse); end
    n_cmp++; if (phase_valid !== 1'b0) begin n_bad++; $display("FAIL lamp_valid got %b want 0", phase_valid); end
    cyc(4, 1'b0);
    cyc(4, 1'b0);
    plan_phase(1, Y, 4, 0);
    while (plan.size() > 0) begin
      e = plan.pop_front();
      cyc(e.ph, e.tk);
      n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL lamp_repulse got %b want 0", err_pulse); end
      n_cmp++; if (phase_valid !== 1'b0) begin n_bad++; $display("FAIL lamp_sync_valid got %b want 0", phase_valid); end
    end
    cyc(2, 1'b0);
    n_cmp++; if (phase_valid !== 1'b1) begin n_bad++; $display("FAIL lamp_resync got %b want 1", phase_valid); end
    n_cmp++; if (phase !== 2'd2) begin n_bad++; $display("FAIL lamp_phase got %0d want 2", phase); end
    plan_phase(2, G, 4, 0);
    plan_phase(3, Y, 4, 0);
    plan.push_back('{0, 1'b0});
    while (plan.size() > 0) begin
      e = plan.pop_front();
      cyc(e.ph, e.tk);
      n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL lamp_after got %b want 0", err_pulse); end
    end
    n_cmp++; if (err_flags !== 5'b10000) begin n_bad++; $display("FAIL lamp_flags2 got %b want 10000", err_flags); end
  endtask

  task automatic test_seq_early();
    do_reset();
    plan_phase(0, G, 4, 0);
    run_plan();
    cyc(2, 1'b0);
    n_cmp++; if (err_flags !== 5'b01000) begin n_bad++; $display("FAIL seq_flags got %b want 01000", err_flags); end
    n_cmp++; if (cycle_count !== 16'd0) begin n_bad++; $display("FAIL seq_count got %0d want 0", cycle_count); end
    do_reset();
    plan_phase(0, G, 4, 2);
    run_plan();
    cyc(1, 1'b0);
    n_cmp++; if (err_flags !== 5'b00001) begin n_bad++; $display("FAIL early_flags got %b want 00001", err_flags); end
    n_cmp++; if (cycle_count !== 16'd0) begin n_bad++; $display("FAIL early_count got %0d want 0", cycle_count); end
  endtask

  task automatic test_clr_rst();
    do_reset();
    plan_phase(0, G, 4, 0);
    run_plan();
    cyc(4, 1'b0);
    cyc(0, 1'b0);
    cyc(1, 1'b0);
    n_cmp++; if (err_flags !== 5'b10000) begin n_bad++; $display("FAIL clr_pre got %b want 10000", err_flags); end
    n_cmp++; if (phase_valid !== 1'b1) begin n_bad++; $display("FAIL clr_valid got %b want 1", phase_valid); end
    plan_phase(1, 1, 4, 0);
    run_plan();
    cyc(2, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (err_flags !== 5'b00100) begin n_bad++; $display("FAIL clr_flags got %b want 00100", err_flags); end
    n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL clr_pulse got %b want 1", err_pulse); end
    plan_phase(2, 2, 4, 0);
    run_plan();
    cyc(2, 1'b1, 1'b1);
    n_cmp++; if (err_flags !== 5'b0) begin n_bad++; $display("FAIL rst_flags got %b want 00000", err_flags); end
    n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_pulse got %b want 0", err_pulse); end
    n_cmp++; if (phase !== 2'd0) begin n_bad++; $display("FAIL rst_phase got %0d want 0", phase); end
    n_cmp++; if (phase_valid !== 1'b1) begin n_bad++; $display("FAIL rst_valid got %b want 1", phase_valid); end
    n_cmp++; if (cycle_count !== 16'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", cycle_count); end
  endtask

  task automatic test_random();
    cyc_t e;
    int   cur, nxt, n, dv, per, post, prints;
    bit   r, clr;
    do_reset();
    cur = 0;
    prints = 0;
    for (int p = 0; p < 300; p++) begin
      dv   = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(0, 3)) - 1;
      n    = (dur(cur) + dv < 0) ? 0 : dur(cur) + dv;
      per  = $urandom_range(1, 4);
      post = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 2);
      plan_phase(cur, n, per, post);
      if ($urandom_range(0, 19) == 0) begin
        nxt = $urandom_range(1, 3);
        for (int j = 0; j < nxt; j++) plan.push_back('{int'($urandom_range(4, 6)), 1'b0});
      end
      cur = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : (cur + 1) % 4;
    end
    while (plan.size() > 0) begin
      e   = plan.pop_front();
      r   = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 29) == 0);
      cyc(e.ph, e.tk, r, clr);
      n_cmp++; if (err_flags !== m_flags) begin n_bad++; if (prints++ < 20) $display("FAIL rand_flags got %b want %b", err_flags, m_flags); end
      n_cmp++; if (err_pulse !== m_pulse) begin n_bad++; if (prints++ < 20) $display("FAIL rand_pulse got %b want %b", err_pulse, m_pulse); end
      n_cmp++; if (phase !== m_ph[1:0]) begin n_bad++; if (prints++ < 20) $display("FAIL rand_phase got %0d want %0d", phase, m_ph); end
      n_cmp++; if (phase_valid !== m_track) begin n_bad++; if (prints++ < 20) $display("FAIL rand_valid got %b want %b", phase_valid, m_track); end
      n_cmp++; if (cycle_count !== m_cycles[CW-1:0]) begin n_bad++; if (prints++ < 20) $display("FAIL rand_count got %0d want %0d", cycle_count, m_cycles[CW-1:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_short();
    test_long();
    test_lamp();
    test_seq_early();
    test_clr_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
